wb_sram_resp: RTL and testbench



---
 rtl/wb_sram_pkg.sv | 8 +
 rtl/wb_sram_resp.sv | 93 +++++++++
 tb/tb_wb_sram_resp.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_pkg.sv
// wb_sram_pkg: shared FSM encoding and window decode for wb_sram_resp
package wb_sram_pkg;
  localparam int WCNT_W = 4;
  typedef enum logic [2:0] {ST_IDLE, ST_ACCESS, ST_RDCAP, ST_WAIT, ST_RESP, ST_ERR} state_t;
  function automatic logic win_hit(input logic [31:0] adr, input logic [31:0] base, input logic [3:0] sel, input int aw);
    return (((adr ^ base) >> (aw + 2)) == 32'd0) && (sel != 4'd0);
  endfunction
endpackage

// File: rtl/wb_sram_resp.sv
// wb_sram_resp: Wishbone responder terminating on a 1-cycle-latency single-port SRAM
module wb_sram_resp
  import wb_sram_pkg::*;
#(
  parameter int          AW        = 9,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          WAIT_CYC  = 0
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  input  logic [3:0]    wbs_sel_i,
  output logic [31:0]   wbs_dat_o,
  output logic          wbs_ack_o,
  output logic          wbs_err_o,
  output logic          sram_csb_o,
  output logic          sram_web_o,
  output logic [3:0]    sram_wmask_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [31:0]   sram_din_o,
  input  logic [31:0]   sram_dout_i
);
  localparam logic [WCNT_W-1:0] WLOAD = WCNT_W'(WAIT_CYC > 0 ? WAIT_CYC - 1 : 0);
  localparam logic NO_WAIT = WAIT_CYC == 0;
  state_t state;
  logic [WCNT_W-1:0] wcnt;
  logic hit;
  assign hit = win_hit(wbs_adr_i, BASE_ADDR, wbs_sel_i, AW);
  // one SRAM access per transaction; ack/err pulse on entry to RESP/ERR, stb loss aborts silently
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state        <= ST_IDLE;
      wcnt         <= '0;
      wbs_ack_o    <= 1'b0;
      wbs_err_o    <= 1'b0;
      wbs_dat_o    <= '0;
      sram_csb_o   <= 1'b1;
      sram_web_o   <= 1'b1;
      sram_wmask_o <= '0;
      sram_addr_o  <= '0;
      sram_din_o   <= '0;
    end else begin
      wbs_ack_o  <= 1'b0;
      wbs_err_o  <= 1'b0;
      sram_csb_o <= 1'b1;
      sram_web_o <= 1'b1;
      case (state)
        ST_IDLE: if (wbs_stb_i) begin
          if (!hit) begin
            state     <= ST_ERR;
            wbs_err_o <= 1'b1;
            wbs_dat_o <= '0;
          end else begin
            state        <= ST_ACCESS;
            sram_csb_o   <= 1'b0;
            sram_web_o   <= !wbs_we_i;
            sram_wmask_o <= wbs_we_i ? wbs_sel_i : 4'h0;
            sram_addr_o  <= wbs_adr_i[AW+1:2];
            sram_din_o   <= wbs_dat_i;
          end
        end
        ST_ACCESS: begin
          if (!wbs_stb_i) state <= ST_IDLE;
          else if (!sram_web_o) begin
            state     <= NO_WAIT ? ST_RESP : ST_WAIT;
            wbs_ack_o <= NO_WAIT;
            wcnt      <= WLOAD;
          end else state <= ST_RDCAP;
        end
        ST_RDCAP: begin
          wbs_dat_o <= sram_dout_i;
          if (!wbs_stb_i) state <= ST_IDLE;
          else begin
            state     <= NO_WAIT ? ST_RESP : ST_WAIT;
            wbs_ack_o <= NO_WAIT;
            wcnt      <= WLOAD;
          end
        end
        ST_WAIT: begin
          if (!wbs_stb_i) state <= ST_IDLE;
          else if (wcnt == '0) begin
            state     <= ST_RESP;
            wbs_ack_o <= 1'b1;
          end else wcnt <= wcnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_sram_resp.sv
// tb_wb_sram_resp: directed bench with a transaction-timing model for two wb_sram_resp instances
module tb_wb_sram_resp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        stb   [2] = '{1'b0, 1'b0};
  logic        we    [2] = '{1'b0, 1'b0};
  logic [31:0] adr   [2] = '{32'h0, 32'h0};
  logic [31:0] dat   [2] = '{32'h0, 32'h0};
  logic [3:0]  sel   [2] = '{4'h0, 4'h0};
  logic [31:0] dat_o [2];
  logic        ack   [2];
  logic        err   [2];
  logic        csb   [2];
  logic        web   [2];
  logic [3:0]  wmask [2];
  logic [8:0]  saddr [2];
  logic [31:0] din   [2];
  logic [31:0] dout  [2];
  logic [31:0] mem    [2][512];
  logic [31:0] shadow [2][512];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int resp_c [2] = '{-1, -1};
  int acc_c  [2] = '{-1, -1};
  int st     [2] = '{-1, -1};
  int busy   [2] = '{0, 0};
  logic        is_err [2] = '{1'b0, 1'b0};
  logic        exp_we [2] = '{1'b0, 1'b0};
  logic [8:0]  exp_a  [2];
  logic [3:0]  exp_m  [2];
  logic [31:0] exp_din[2];
  logic [31:0] exp_d  [2];
  localparam logic [31:0] BASE1 = 32'h1000_0000;

  always #5 clk = ~clk;

  wb_sram_resp #(.AW(9), .BASE_ADDR(32'h0), .WAIT_CYC(0)) u0 (
    .wb_clk(clk), .wb_rst_n(rst_n), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]), .wbs_adr_i(adr[0]),
    .wbs_dat_i(dat[0]), .wbs_sel_i(sel[0]), .wbs_dat_o(dat_o[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0]),
    .sram_csb_o(csb[0]), .sram_web_o(web[0]), .sram_wmask_o(wmask[0]), .sram_addr_o(saddr[0]),
    .sram_din_o(din[0]), .sram_dout_i(dout[0]));

  wb_sram_resp #(.AW(9), .BASE_ADDR(BASE1), .WAIT_CYC(3)) u1 (
    .wb_clk(clk), .wb_rst_n(rst_n), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]), .wbs_adr_i(adr[1]),
    .wbs_dat_i(dat[1]), .wbs_sel_i(sel[1]), .wbs_dat_o(dat_o[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1]),
    .sram_csb_o(csb[1]), .sram_web_o(web[1]), .sram_wmask_o(wmask[1]), .sram_addr_o(saddr[1]),
    .sram_din_o(din[1]), .sram_dout_i(dout[1]));

  // SRAM macro stand-in: masked write and 1-cycle read on every selected edge
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!csb[k]) begin
        if (!web[k]) for (int b = 0; b < 4; b++) if (wmask[k][b]) mem[k][saddr[k]][8*b +: 8] <= din[k][8*b +: 8];
        dout[k] <= mem[k][saddr[k]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int wcyc(input int k);
    return k == 1 ? 3 : 0;
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return k == 1 ? BASE1 : 32'h0;
  endfunction

  // transaction model: works out csb/ack/err cycle numbers from accepted requests
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        resp_c[k] = -1;
        acc_c[k] = -1;
        st[k] = -1;
        busy[k] = 0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (!is_err[k] && resp_c[k] >= 0 && cyc - 1 >= st[k] && cyc - 1 < resp_c[k] && !stb[k]) begin
          resp_c[k] = -1;
          busy[k] = cyc + 1;
        end else if (cyc >= busy[k] && stb[k]) begin
          st[k] = cyc;
          exp_a[k] = adr[k][10:2];
          exp_we[k] = we[k];
          exp_m[k] = we[k] ? sel[k] : 4'h0;
          exp_din[k] = dat[k];
          if (adr[k][31:11] != base_of(k) >> 11 || sel[k] == 4'h0) begin
            is_err[k] = 1'b1;
            resp_c[k] = cyc;
            acc_c[k] = -1;
          end else begin
            is_err[k] = 1'b0;
            acc_c[k] = cyc;
            resp_c[k] = cyc + (we[k] ? 1 : 2) + wcyc(k);
            if (we[k]) begin
              for (int b = 0; b < 4; b++) if (sel[k][b]) shadow[k][exp_a[k]][8*b +: 8] = dat[k][8*b +: 8];
            end else exp_d[k] = shadow[k][exp_a[k]];
          end
          busy[k] = resp_c[k] + 2;
        end
      end
    end
  end

  // per-cycle compare of both instances against the model
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        logic ea, ee, ec;
        ea = !is_err[k] && cyc == resp_c[k];
        ee = is_err[k] && cyc == resp_c[k];
        ec = !(cyc == acc_c[k]);
        chk($sformatf("ack%0d@%0d", k, cyc), 32'(ack[k]), 32'(ea));
        chk($sformatf("err%0d@%0d", k, cyc), 32'(err[k]), 32'(ee));
        chk($sformatf("csb%0d@%0d", k, cyc), 32'(csb[k]), 32'(ec));
        if (ea && !exp_we[k]) chk($sformatf("rdata%0d@%0d", k, cyc), dat_o[k], exp_d[k]);
        if (ee) chk($sformatf("errdata%0d@%0d", k, cyc), dat_o[k], 32'h0);
        if (!ec) begin
          chk($sformatf("web%0d@%0d", k, cyc), 32'(web[k]), 32'(!exp_we[k]));
          chk($sformatf("addr%0d@%0d", k, cyc), 32'(saddr[k]), 32'(exp_a[k]));
          chk($sformatf("wmask%0d@%0d", k, cyc), 32'(wmask[k]), 32'(exp_m[k]));
          if (exp_we[k]) chk($sformatf("din%0d@%0d", k, cyc), din[k], exp_din[k]);
        end
      end
    end
  end

  task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat, output logic ga,
                      output logic ge, output logic c1, output logic [8:0] a1, output logic [3:0] m1);
    @(negedge clk);
    stb[k] = 1'b1; we[k] = w; adr[k] = a; dat[k] = d; sel[k] = s;
    lat = 0; ga = 1'b0; ge = 1'b0; rd = '0; c1 = 1'b1; a1 = '0; m1 = '0;
    while (!ga && !ge && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        c1 = csb[k]; a1 = saddr[k]; m1 = wmask[k];
      end
      ga = ack[k]; ge = err[k]; rd = dat_o[k];
    end
    stb[k] = 1'b0;
    if (!ga && !ge) begin
      total++;
      bad++;
      $display("FAIL timeout%0d: no ack/err within 40 cycles", k);
    end
  endtask

  task automatic run(input string nm, input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int elat, input logic eack, input logic [31:0] ed,
                     input logic [8:0] ea1, input logic [3:0] em1);
    logic [31:0] rd;
    int lat;
    logic ga, ge, c1;
    logic [8:0] a1;
    logic [3:0] m1;
    xfer(k, w, a, d, s, rd, lat, ga, ge, c1, a1, m1);
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_ack"}, 32'(ga), 32'(eack));
    chk({nm, "_err"}, 32'(ge), 32'(!eack));
    chk({nm, "_csb1"}, 32'(c1), 32'(!eack));
    if (eack) begin
      chk({nm, "_addr1"}, 32'(a1), 32'(ea1));
      chk({nm, "_mask1"}, 32'(m1), 32'(em1));
    end
    if (!eack || !w) chk({nm, "_data"}, rd, ed);
  endtask

  initial begin
    int na, nc, first, last;
    stb[0] = 1'b1;
    stb[1] = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ack%0d", k), 32'(ack[k]), 32'h0);
      chk($sformatf("rst_err%0d", k), 32'(err[k]), 32'h0);
      chk($sformatf("rst_csb%0d", k), 32'(csb[k]), 32'h1);
      chk($sformatf("rst_dat%0d", k), dat_o[k], 32'h0);
    end
    stb[0] = 1'b0;
    stb[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run("wr_full", 0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2, 1'b1, 32'h0, 9'd4, 4'hF);
    run("rd_full", 0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 3, 1'b1, 32'hDEAD_BEEF, 9'd4, 4'h0);
    run("wr_part", 0, 1'b1, 32'h0000_0010, 32'h0000_5A00, 4'b0010, 2, 1'b1, 32'h0, 9'd4, 4'b0010);
    run("rd_part", 0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 3, 1'b1, 32'hDEAD_5AEF, 9'd4, 4'h0);
    run("err_win", 0, 1'b1, 32'h0000_0800, 32'h1111_1111, 4'hF, 1, 1'b0, 32'h0, 9'd0, 4'h0);
    run("err_sel", 0, 1'b1, 32'h0000_0010, 32'h2222_2222, 4'h0, 1, 1'b0, 32'h0, 9'd0, 4'h0);
    run("w3_wr", 1, 1'b1, 32'h1000_0020, 32'h1234_5678, 4'hF, 5, 1'b1, 32'h0, 9'd8, 4'hF);
    run("w3_rd", 1, 1'b0, 32'h1000_0020, 32'h0, 4'hF, 6, 1'b1, 32'h1234_5678, 9'd8, 4'h0);
    run("w3_err", 1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1, 1'b0, 32'h0, 9'd0, 4'h0);
    @(negedge clk);
    stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h0000_0030; dat[0] = 32'hA5A5_0F0F; sel[0] = 4'hF;
    na = 0; nc = 0; first = 0; last = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (ack[0]) begin
        na++;
        if (first == 0) first = n;
        last = n;
      end
      if (!csb[0]) nc++;
    end
    stb[0] = 1'b0;
    chk("b2b_acks", 32'(na), 32'd4);
    chk("b2b_csbs", 32'(nc), 32'd4);
    chk("b2b_first", 32'(first), 32'd2);
    chk("b2b_last", 32'(last), 32'd11);
    run("b2b_rd", 0, 1'b0, 32'h0000_0030, 32'h0, 4'hF, 3, 1'b1, 32'hA5A5_0F0F, 9'd12, 4'h0);
    @(negedge clk);
    stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h0000_0010; sel[0] = 4'hF;
    repeat (2) @(negedge clk);
    stb[0] = 1'b0;
    na = 0;
    repeat (6) begin
      @(negedge clk);
      na += int'(ack[0] | err[0]);
    end
    chk("abort_quiet", 32'(na), 32'd0);
    run("abort_next", 0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 3, 1'b1, 32'hDEAD_5AEF, 9'd4, 4'h0);
    @(negedge clk);
    stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h0000_0010; sel[0] = 4'hF;
    @(posedge clk);
    #1 chk("rst_mid_csb_low", 32'(csb[0]), 32'h0);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_csb_async", 32'(csb[0]), 32'h1);
    stb[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    na = 0;
    repeat (6) begin
      @(negedge clk);
      na += int'(ack[0] | err[0]);
    end
    chk("rst_mid_noack", 32'(na), 32'd0);
    run("post_rst_rd", 0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 3, 1'b1, 32'hDEAD_5AEF, 9'd4, 4'h0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
